cube_layer_scanner: RTL and testbench
=====================================

// Module: cube_layer_scanner
// PURPOSE
//  Downstream display stage of the cube controller: consumes voxel frames written by the UART
//  command decoder into a double-buffered frame store and drives the cube GPIO header.
//  Layer-multiplexed scan: each layer's 64 column bits are shifted serially into a 74HC595
//  chain, latched, then one layer transistor is enabled for a dwell period.
//  Bank swap happens only at frame boundaries, so the display never tears.
// PARAMETERS
//  LAYERS        8      number of cube layers (rows of layer_en)
//  COLS          64     column bits per layer (8 bytes)
//  CLK_DIV       4      clk cycles per ser_clk half-period (>=1)
//  BLANK_CYCLES  16     ghost-suppression blanking before shifting each layer
//  DWELL_CYCLES  5000   cycles a layer stays lit
// PORTS
//  clk          in   1     system clock (50 MHz)
//  reset        in   1     synchronous, active-high
//  wr_en        in   1     write strobe into back bank
//  wr_addr      in   6     [5:3] layer, [2:0] byte index within layer
//  wr_data      in   8     column byte; bit7 = lowest column of that byte
//  swap_req     in   1     one-cycle pulse: present back bank at next frame boundary
//  swap_pending out  1     swap requested, not yet performed
//  frame_tick   out  1     one-cycle pulse when last layer's dwell ends
//  ser_data     out  1     shift-register serial data
//  ser_clk      out  1     shift clock (data sampled on rising edge)
//  latch        out  1     storage-register clock
//  oe_n         out  1     shift-register output enable, active low
//  layer_en     out  LAYERS one-hot layer drive, active high
// BEHAVIOUR
//  Reset: ser_data=0, ser_clk=0, latch=0, oe_n=1, layer_en=0, frame_tick=0, swap_pending=0,
//   front bank=0, layer index=0, FSM=BLANK. Frame store contents are not cleared.
//  FSM: BLANK -> SHIFT -> LATCH -> DISPLAY -> BLANK (next layer).
//   BLANK: oe_n=1, layer_en=0 for BLANK_CYCLES; the front-bank byte for the layer is prefetched.
//   SHIFT: COLS bits are sent, byte 7 first, MSB first. Each bit: ser_data set with ser_clk=0
//    for CLK_DIV cycles, then ser_clk=1 for CLK_DIV cycles. Total COLS*2*CLK_DIV cycles.
//   LATCH: ser_clk=0, latch=1 for CLK_DIV cycles.
//   DISPLAY: oe_n=0, layer_en=1<<layer for DWELL_CYCLES. Then layer increments; it wraps
//    LAYERS-1 -> 0.
//  Frame boundary: the last DISPLAY cycle of layer LAYERS-1. frame_tick=1 for that cycle.
//   If swap_pending, the front bank toggles on the same edge and swap_pending clears.
//  swap_req in the same cycle as the boundary: the swap takes effect at the NEXT boundary
//   (pending is set, not consumed). Repeated swap_req while pending: no effect.
//  Writes always target the back bank (~front), one cycle latency; never visible until a swap.
//   A write and a swap on the same edge: the write lands in the old back bank, which is the
//   new front.
//  Reset mid-scan: all outputs return to reset values on the next edge; layer_en is never
//   glitched on.
//  layer_en and oe_n=0 are never both active outside DISPLAY.
// CONFIGURATION
//  CUBE_SCAN_BRIGHTNESS_EN defined: adds input bright[3:0]. In DISPLAY, a 4-bit PWM counter
//   (wraps 15->0 each cycle) drives oe_n=0 only when cnt<bright. bright=0 means dark;
//   bright=15 means 15/16 duty. layer_en is unchanged.
//  Not defined: no port; oe_n=0 for the full dwell.
// STRUCTURE
//  cube_pkg: scan_state_e enum {BLANK,SHIFT,LATCH,DISPLAY}, CUBE_LAYERS, CUBE_COLS,
//   CUBE_ADDR_W; shared with the UART decoder.
//  Sub-module cube_frame_buffer: 2x64-byte banks, registered read, write port to the back
//   bank, read port from the front bank.
//  Scan FSM, bit/byte/dwell counters and the swap logic stay in this module.
// TESTING
//  Reset, then write bank1 layer0 bytes 0..7 = 8'hA5, pulse swap_req, run one frame
//   -> frame_tick once, swap_pending falls, next layer0 shifts 0xA5 x8, MSB first.
//  CLK_DIV=1, BLANK=2, DWELL=10 -> per-layer period exactly 2+128+1+10=141 cycles;
//   layer_en walks 01,02..80, then 01.
//  swap_req on the frame_tick cycle -> swap_pending held, bank toggles one frame later.
//  reset asserted mid-SHIFT of layer 5 -> next cycle oe_n=1, layer_en=0; restart at layer 0.
//  Check every cycle -> oe_n==0 or layer_en!=0 only in DISPLAY; latch never high while
//   ser_clk=1.
//  CUBE_SCAN_BRIGHTNESS_EN, bright=4 -> oe_n low exactly 4 of every 16 DISPLAY cycles.

Source files
------------

// File: rtl/cube_pkg.sv
// Shared cube-controller definitions: scan states and frame-store geometry.
// Used by the layer scanner and the UART command decoder.
package cube_pkg;

   localparam int CUBE_LAYERS = 8;
   localparam int CUBE_COLS   = 64;
   localparam int CUBE_BYTES  = CUBE_COLS / 8;
   localparam int CUBE_ADDR_W = $clog2(CUBE_LAYERS * CUBE_BYTES);

   typedef enum logic [1:0] {
      BLANK,
      SHIFT,
      LATCH,
      DISPLAY
   } scan_state_e;

endpackage

// File: rtl/cube_frame_buffer.sv
// Double-buffered voxel frame store: two byte banks selected by a bank bit,
// one write port and one registered read port. Contents are never cleared.
module cube_frame_buffer
   import cube_pkg::*;
#(
   parameter int ADDR_W = CUBE_ADDR_W
) (
   input  logic              clk_i,
   input  logic              wr_en_i,
   input  logic              wr_bank_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [7:0]        wr_data_i,
   input  logic              rd_bank_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [7:0]        rd_data_o
);

   logic [7:0] mem_q [2**(ADDR_W+1)];
   logic [7:0] rd_data_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
      end
      rd_data_q <= mem_q[{rd_bank_i, rd_addr_i}];
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/cube_layer_scanner.sv
// Layer-multiplexed cube scanner: shifts each layer into a 74HC595 chain, latches,
// then lights the layer. Optional PWM brightness via CUBE_SCAN_BRIGHTNESS_EN.
module cube_layer_scanner
   import cube_pkg::*;
#(
   parameter int LAYERS       = CUBE_LAYERS,
   parameter int COLS         = CUBE_COLS,
   parameter int CLK_DIV      = 4,
   parameter int BLANK_CYCLES = 16,
   parameter int DWELL_CYCLES = 5000,
   localparam int LAYER_W     = $clog2(LAYERS),
   localparam int BYTES       = COLS / 8,
   localparam int BYTE_W      = $clog2(BYTES),
   localparam int ADDR_W      = LAYER_W + BYTE_W
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [7:0]        wr_data_i,
   input  logic              swap_req_i,
   output logic              swap_pending_o,
   output logic              frame_tick_o,
   output logic              ser_data_o,
   output logic              ser_clk_o,
   output logic              latch_o,
   output logic              oe_n_o,
   output logic [LAYERS-1:0] layer_en_o
`ifdef CUBE_SCAN_BRIGHTNESS_EN
   ,
   input  logic [3:0]        bright_i
`endif
);

   localparam int BIT_W   = $clog2(COLS);
   localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES)
                            ? ((DWELL_CYCLES > CLK_DIV) ? DWELL_CYCLES : CLK_DIV)
                            : ((BLANK_CYCLES > CLK_DIV) ? BLANK_CYCLES : CLK_DIV);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0]   BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0]   DIV_LAST   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0]   DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(COLS - 1);
   localparam logic [LAYER_W-1:0] LAYER_LAST = LAYER_W'(LAYERS - 1);

   scan_state_e        state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               half_q, half_d;
   logic [BIT_W-1:0]   bit_q, bit_d;
   logic [LAYER_W-1:0] layer_q, layer_d;
   logic               front_q, front_d;
   logic               pend_q, pend_d;
   logic               frame_end;
   logic [7:0]         rd_data;
   logic               rd_bank;
   logic [LAYER_W-1:0] rd_layer;
   logic [BIT_W-1:0]   rd_bit;
   logic [BYTE_W-1:0]  rd_byte;

   assign frame_end = (state_q == DISPLAY) && (cnt_q == DWELL_LAST) && (layer_q == LAYER_LAST);

   // Read address follows next-state so rd_data matches the current byte every cycle.
   assign rd_bank  = reset_i ? 1'b0 : front_d;
   assign rd_layer = reset_i ? '0 : layer_d;
   assign rd_bit   = reset_i ? '0 : bit_d;
   assign rd_byte  = BYTE_W'(BYTES - 1) - rd_bit[BIT_W-1:3];

   cube_frame_buffer #(
      .ADDR_W(ADDR_W)
   ) u_fb (
      .clk_i    (clk_i),
      .wr_en_i  (wr_en_i),
      .wr_bank_i(~front_q),
      .wr_addr_i(wr_addr_i),
      .wr_data_i(wr_data_i),
      .rd_bank_i(rd_bank),
      .rd_addr_i({rd_layer, rd_byte}),
      .rd_data_o(rd_data)
   );

`ifdef CUBE_SCAN_BRIGHTNESS_EN
   logic [3:0] pwm_q, pwm_d;
   assign pwm_d = (state_q == DISPLAY) ? pwm_q + 4'd1 : 4'd0;
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= BLANK;
         cnt_q   <= '0;
         half_q  <= 1'b0;
         bit_q   <= '0;
         layer_q <= '0;
         front_q <= 1'b0;
         pend_q  <= 1'b0;
`ifdef CUBE_SCAN_BRIGHTNESS_EN
         pwm_q   <= 4'd0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         half_q  <= half_d;
         bit_q   <= bit_d;
         layer_q <= layer_d;
         front_q <= front_d;
         pend_q  <= pend_d;
`ifdef CUBE_SCAN_BRIGHTNESS_EN
         pwm_q   <= pwm_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      half_d  = half_q;
      bit_d   = bit_q;
      layer_d = layer_q;
      front_d = front_q;
      pend_d  = pend_q;
      unique case (state_q)
         BLANK: begin
            if (cnt_q == BLANK_LAST) begin
               state_d = SHIFT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SHIFT: begin
            if (cnt_q == DIV_LAST) begin
               cnt_d  = '0;
               half_d = ~half_q;
               if (half_q) begin
                  if (bit_q == BIT_LAST) begin
                     state_d = LATCH;
                     bit_d   = '0;
                  end else begin
                     bit_d = bit_q + 1'b1;
                  end
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         LATCH: begin
            if (cnt_q == DIV_LAST) begin
               state_d = DISPLAY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DISPLAY: begin
            if (cnt_q == DWELL_LAST) begin
               state_d = BLANK;
               cnt_d   = '0;
               layer_d = (layer_q == LAYER_LAST) ? '0 : layer_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = BLANK;
      endcase
      // A request arriving on the boundary itself waits for the following frame.
      if (frame_end && pend_q) begin
         front_d = ~front_q;
         pend_d  = 1'b0;
      end else if (swap_req_i) begin
         pend_d = 1'b1;
      end
   end

   always_comb begin
      ser_data_o = 1'b0;
      ser_clk_o  = 1'b0;
      latch_o    = 1'b0;
      oe_n_o     = 1'b1;
      layer_en_o = '0;
      unique case (state_q)
         SHIFT: begin
            ser_data_o = rd_data[~bit_q[2:0]];
            ser_clk_o  = half_q;
         end
         LATCH: latch_o = 1'b1;
         DISPLAY: begin
            layer_en_o = LAYERS'(1) << layer_q;
`ifdef CUBE_SCAN_BRIGHTNESS_EN
            oe_n_o     = !(pwm_q < bright_i);
`else
            oe_n_o     = 1'b0;
`endif
         end
         default: ;
      endcase
   end

   assign frame_tick_o   = frame_end;
   assign swap_pending_o = pend_q;

endmodule

// File: tb/tb_cube_layer_scanner.sv
// Self-checking bench for cube_layer_scanner: timeline-based reference model plus
// directed literal checks. Define CUBE_SCAN_BRIGHTNESS_EN to exercise the PWM build.
module tb_cube_layer_scanner;

   localparam int LAYERS  = 8;
   localparam int COLS    = 64;
   localparam int CD      = 1;
   localparam int BLANK_N = 2;
`ifdef CUBE_SCAN_BRIGHTNESS_EN
   localparam int DWELL_N    = 32;
   localparam int PERIOD_LIT = 163;
`else
   localparam int DWELL_N    = 10;
   localparam int PERIOD_LIT = 141;
`endif
   localparam int S_LEN = COLS * 2 * CD;
   localparam int P     = BLANK_N + S_LEN + CD + DWELL_N;
   localparam int F     = LAYERS * P;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, wr_en, swap_req;
   logic [5:0]  wr_addr;
   logic [7:0]  wr_data;
   logic [3:0]  bright;
   logic        swap_pending_o, frame_tick_o, ser_data_o, ser_clk_o, latch_o, oe_n_o;
   logic [7:0]  layer_en_o;

   cube_layer_scanner #(
      .LAYERS(LAYERS), .COLS(COLS), .CLK_DIV(CD),
      .BLANK_CYCLES(BLANK_N), .DWELL_CYCLES(DWELL_N)
   ) dut (
      .clk_i(clk), .reset_i(reset), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
      .wr_data_i(wr_data), .swap_req_i(swap_req), .swap_pending_o(swap_pending_o),
      .frame_tick_o(frame_tick_o), .ser_data_o(ser_data_o), .ser_clk_o(ser_clk_o),
      .latch_o(latch_o), .oe_n_o(oe_n_o), .layer_en_o(layer_en_o)
`ifdef CUBE_SCAN_BRIGHTNESS_EN
      , .bright_i(bright)
`endif
   );

   int checks = 0;
   int fails  = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic expired(input string name);
      checks++;
      fails++;
      $display("FAIL %s wait expired at %0t", name, $time);
   endtask

   // Reference model: position in the frame timeline plus two byte banks.
   int         mt;
   bit         mfront, mpend, mvalid;
   logic [7:0] mmem   [2][64];
   bit         mknown [2][64];

   initial begin
      int layer, off, s, b, byte_i, d, wb;
      logic exp_sclk, exp_latch, exp_oe, exp_tick, sd_chk, exp_sd;
      logic [7:0] exp_le;
      mvalid = 0; mt = 0; mfront = 0; mpend = 0;
      for (int i = 0; i < 64; i++) begin
         mknown[0][i] = 0;
         mknown[1][i] = 0;
      end
      forever begin
         @(posedge clk);
         if (wr_en) begin
            wb = mfront ? 0 : 1;
            mmem[wb][wr_addr]   = wr_data;
            mknown[wb][wr_addr] = 1;
         end
         if (reset) begin
            mt = 0; mfront = 0; mpend = 0; mvalid = 1;
         end else if (mvalid) begin
            if (mt == F - 1 && mpend) begin
               mfront = ~mfront;
               mpend  = 0;
            end else if (swap_req) begin
               mpend = 1;
            end
            mt = (mt + 1) % F;
         end
         @(negedge clk);
         if (mvalid) begin
            layer = mt / P;
            off   = mt % P;
            exp_sclk = 0; exp_latch = 0; exp_oe = 1; exp_tick = 0; exp_le = 8'h00;
            sd_chk = 0; exp_sd = 0;
            if (off < BLANK_N) begin
               sd_chk = (mt == 0);
            end else if (off < BLANK_N + S_LEN) begin
               s        = off - BLANK_N;
               b        = s / (2 * CD);
               exp_sclk = ((s % (2 * CD)) >= CD);
               byte_i   = COLS / 8 - 1 - b / 8;
               if (mknown[mfront][layer * 8 + byte_i]) begin
                  sd_chk = 1;
                  exp_sd = mmem[mfront][layer * 8 + byte_i][7 - (b % 8)];
               end
            end else if (off < BLANK_N + S_LEN + CD) begin
               exp_latch = 1;
            end else begin
               d        = off - (BLANK_N + S_LEN + CD);
               exp_le   = 8'(1 << layer);
`ifdef CUBE_SCAN_BRIGHTNESS_EN
               exp_oe   = !((d % 16) < int'(bright));
`else
               exp_oe   = 0;
`endif
               exp_tick = (layer == LAYERS - 1) && (off == P - 1);
            end
            chk("outputs{tick,sclk,latch,oe_n,layer_en,pend}",
                {frame_tick_o, ser_clk_o, latch_o, oe_n_o, layer_en_o, swap_pending_o},
                {exp_tick, exp_sclk, exp_latch, exp_oe, exp_le, mpend});
            if (sd_chk) chk("ser_data", ser_data_o, exp_sd);
            if (latch_o) chk("latch_with_ser_clk", ser_clk_o, 1'b0);
         end
      end
   end

   task automatic wr_byte(input int a, input logic [7:0] d);
      wr_en = 1; wr_addr = 6'(a); wr_data = d;
      @(posedge clk); #1;
      wr_en = 0;
   endtask

   task automatic wait_tick(input string name, input int bound);
      int n = 0;
      while (!frame_tick_o && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (!frame_tick_o) expired(name);
   endtask

   logic [7:0] walk [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

   initial begin
      int ticks, nbits, k, cyc, low;
      logic prev_sclk;
      logic [7:0] prev_le;
      logic [63:0] bits;
      logic [7:0] seq [9];
      int tstamp [9];
      reset = 1; wr_en = 0; swap_req = 0; wr_addr = 0; wr_data = 0; bright = 4'd4;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_oe_n", oe_n_o, 1'b1);
      chk("reset_layer_en", layer_en_o, 8'h00);
      chk("reset_ser_clk", ser_clk_o, 1'b0);
      chk("reset_ser_data", ser_data_o, 1'b0);
      chk("reset_latch", latch_o, 1'b0);
      chk("reset_frame_tick", frame_tick_o, 1'b0);
      chk("reset_swap_pending", swap_pending_o, 1'b0);
      @(posedge clk); #1;
      reset = 0;

      // Load back bank 1: layer 0 all 0xA5, rest random; then request a swap.
      for (int a = 0; a < 64; a++) wr_byte(a, (a < 8) ? 8'hA5 : 8'($urandom));
      swap_req = 1;
      @(posedge clk); #1;
      swap_req = 0;
      @(negedge clk);
      chk("swap_pending_set", swap_pending_o, 1'b1);
      wait_tick("first_frame_tick", 2 * F);
      ticks = 0; nbits = 0; bits = '0; prev_sclk = ser_clk_o;
      for (int i = 0; i < F; i++) begin
         if (i > 0) @(negedge clk);
         if (frame_tick_o) ticks++;
         if (i == 1) chk("swap_pending_clear", swap_pending_o, 1'b0);
         if (ser_clk_o && !prev_sclk && nbits < 64) begin
            bits = {bits[62:0], ser_data_o};
            nbits++;
         end
         prev_sclk = ser_clk_o;
      end
      chk("ticks_per_frame", ticks, 1);
      chk("layer0_bit_count", nbits, 64);
      chk("layer0_pattern", bits, 64'hA5A5_A5A5_A5A5_A5A5);

      // Layer walk and per-layer period.
      k = 0; cyc = 0; prev_le = layer_en_o;
      while (k < 9 && cyc < 10 * P + 10) begin
         @(negedge clk);
         cyc++;
         if (layer_en_o != 8'h00 && prev_le == 8'h00) begin
            seq[k] = layer_en_o;
            tstamp[k] = cyc;
            k++;
         end
         prev_le = layer_en_o;
      end
      if (k < 9) expired("layer_walk");
      else begin
         for (int j = 0; j < 9; j++) chk("layer_walk", seq[j], walk[j]);
         for (int j = 1; j < 9; j++) chk("layer_period", tstamp[j] - tstamp[j-1], PERIOD_LIT);
      end

      // Fill back bank 0, request swap on the frame_tick cycle itself.
      for (int a = 0; a < 64; a++) wr_byte(a, 8'($urandom));
      wait_tick("tick_for_late_swap", 2 * F);
      swap_req = 1;
      @(posedge clk); #1;
      swap_req = 0;
      @(negedge clk);
      chk("swap_on_tick_held", swap_pending_o, 1'b1);
      cyc = 1;
      while (!frame_tick_o && cyc < F + 10) begin
         @(negedge clk);
         cyc++;
      end
      chk("tick_spacing", cyc, PERIOD_LIT * LAYERS);
      @(negedge clk);
      chk("late_swap_done", swap_pending_o, 1'b0);

      // Random traffic.
      repeat (3 * F) begin
         wr_en    = ($urandom % 4 == 0);
         wr_addr  = 6'($urandom);
         wr_data  = 8'($urandom);
         swap_req = ($urandom % 300 == 0);
`ifdef CUBE_SCAN_BRIGHTNESS_EN
         bright   = 4'($urandom);
`endif
         @(posedge clk); #1;
      end
      wr_en = 0; swap_req = 0; bright = 4'd4;

      // Reset in the middle of layer 5's shift.
      cyc = 0;
      while (layer_en_o != 8'h10 && cyc < F + 10) begin @(negedge clk); cyc++; end
      if (layer_en_o != 8'h10) expired("find_layer4");
      cyc = 0;
      while (layer_en_o != 8'h00 && cyc < P) begin @(negedge clk); cyc++; end
      repeat (BLANK_N + 20) @(negedge clk);
      reset = 1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("midreset_oe_n", oe_n_o, 1'b1);
      chk("midreset_layer_en", layer_en_o, 8'h00);
      chk("midreset_ser_clk", ser_clk_o, 1'b0);
      chk("midreset_latch", latch_o, 1'b0);
      chk("midreset_pending", swap_pending_o, 1'b0);
      @(posedge clk); #1;
      reset = 0;
      cyc = 0;
      while (layer_en_o == 8'h00 && cyc < P + 10) begin @(negedge clk); cyc++; end
      chk("restart_layer", layer_en_o, 8'h01);
      chk("restart_latency", cyc, BLANK_N + S_LEN + CD + 1);
`ifdef CUBE_SCAN_BRIGHTNESS_EN
      low = 0;
      for (int j = 0; j < DWELL_N; j++) begin
         if (j > 0) @(negedge clk);
         if (!oe_n_o) low++;
      end
      chk("pwm_low_cycles", low, 8);
`else
      low = 0;
`endif

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
